ll_rd_ctrl: RTL
===============

Name: ll_rd_ctrl

Overview:
- Read controller for the linked-list store; the consumer side of the next-pointer allocator.
- Accepts pop requests and reads the head node (data plus next-pointer field) from node memory, then presents the data.
- On response acceptance, returns the freed node pointer to the allocator via a return_nxt_ptr / pos_2_return_nxt_ptr pulse and advances head.
- Sits between req_resp_intf (request/response), the node memory read port, and the allocator.

Parameters:
- DATA_DEPTH, 16, number of list nodes.
- PTR_WD, $clog2(DATA_DEPTH), node pointer width.
- DATA_WD, 32, payload width per node.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-high: asserted (1) = reset
- rd_req_vld  in  1  pop request valid
- rd_req_peek  in  1  qualifies rd_req_vld; only meaningful with LL_PEEK_EN
- rd_req_rdy  out  1  request accepted when vld&rdy
- rd_resp_vld  out  1  response valid
- rd_resp_rdy  in  1  response consumed when vld&rdy
- rd_resp_data  out  DATA_WD  node payload
- rd_resp_err  out  1  pop on empty list
- head_ld  in  1  write controller wrote the first node into an empty list
- head_ld_ptr  in  PTR_WD  pointer of that node
- ll_empty  in  1  from allocator
- make_ll_empty  in  1  flush command
- mem_rd_en  out  1  node memory read strobe
- mem_rd_addr  out  PTR_WD  node address
- mem_rd_data  in  DATA_WD  payload, valid 1 cycle after mem_rd_en
- mem_rd_nxt_ptr  in  PTR_WD  next field, valid 1 cycle after mem_rd_en
- return_nxt_ptr  out  1  one-cycle pulse freeing a node
- pos_2_return_nxt_ptr  out  PTR_WD  node being freed

Behaviour:
- Reset: state IDLE, head_ptr=0, head_vld=0. All outputs 0 except rd_req_rdy=1.
- Tail convention: a node whose next field equals its own address is the tail.
- IDLE: rd_req_rdy=1.
  - On vld&rdy with head_vld=1: go to ISSUE.
  - On vld&rdy with head_vld=0: go to RESP with rd_resp_err=1 and data 0.
- ISSUE: mem_rd_en=1 and mem_rd_addr=head_ptr for exactly one cycle; go to WAIT.
- WAIT: capture mem_rd_data and mem_rd_nxt_ptr into the response holding register; go to RESP.
- RESP: rd_resp_vld=1; data and err held stable until rd_resp_rdy. On the acceptance cycle:
  - Non-error: in the next cycle, return_nxt_ptr=1 and pos_2_return_nxt_ptr=old head_ptr (single pulse).
  - Non-error: if captured nxt == old head, head_vld<=0; else head_ptr<=captured nxt.
  - Go to IDLE.
- Latency: request accept to rd_resp_vld is 3 cycles (error case: 1 cycle). The return pulse comes 1 cycle after response acceptance.
- head_ld: sampled in any state; loads head_ptr and sets head_vld.
  - Only legal when head_vld=0. If head_vld=1, ignore it.
  - If head_ld coincides with the acceptance that empties the list, the load wins: head_vld=1, head_ptr=head_ld_ptr.
- ll_empty=1 with head_vld=1: inconsistency; force head_vld<=0 and flag (not fatal). With LL_PEEK_EN absent this is the only use of ll_empty.
- make_ll_empty: highest priority.
  - Next cycle: state IDLE, head_vld=0, rd_resp_vld=0.
  - No return pulse for any in-flight node, since the allocator resets itself.
  - An in-flight memory read is discarded.
- No new request is accepted while not IDLE (one outstanding op).

Optional Feature:
- LL_PEEK_EN defined: a request with rd_req_peek=1 runs the same ISSUE/WAIT/RESP flow, but on acceptance emits no return pulse and leaves head unchanged.
- LL_PEEK_EN absent: rd_req_peek is ignored and all requests are pops.

Decomposition:
- Package ll_pkg holds:
  - DATA_DEPTH, PTR_WD, DATA_WD constants;
  - typedef ptr_t (logic [PTR_WD-1:0]);
  - typedef rd_state_e {IDLE, ISSUE, WAIT, RESP};
  - struct rd_resp_t {data, err}.
- FSM, head register and response holding register live inline; no sub-module is needed.

Test Plan:
- head_ld ptr=5, memory[5]={data=0xA5A5, nxt=5}; pop.
  - Required: mem_rd_addr=5 at cycle +1; rd_resp_data=0xA5A5 at +3, err=0.
  - Required: return pulse with pos=5; head_vld=0 after.
- Chain 2→7→9(tail), head_ld 2; three pops with rd_resp_rdy=1.
  - Required: data in order 2,7,9; return pulses at pos 2,7,9.
  - Required: fourth pop gives err=1 at +1 and no pulse.
- Hold rd_resp_rdy=0 for 4 cycles in RESP.
  - Required: rd_resp_vld and data stable, rd_req_rdy=0, no return pulse until rdy.
- make_ll_empty in WAIT.
  - Required: next cycle IDLE, rd_resp_vld=0, no return pulse; next pop gives err=1.
- Last node accepted while head_ld ptr=3 in the same cycle.
  - Required: head_vld=1, head_ptr=3; next pop reads address 3.
- LL_PEEK_EN: peek on head 4.
  - Required: data returned, no pulse; the following pop reads address 4 again and pulses pos=4.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared types and sizing for the linked-list store read path.
package ll_pkg;

  localparam int unsigned DATA_DEPTH = 16;
  localparam int unsigned PTR_WD     = $clog2(DATA_DEPTH);
  localparam int unsigned DATA_WD    = 32;

  typedef logic [PTR_WD-1:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } rd_state_e;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic               err;
  } rd_resp_t;

endpackage

// File: rtl/ll_rd_ctrl.sv
// Linked-list read controller: pops the head node, returns it to the allocator, advances head.
// Optional LL_PEEK_EN: requests with rd_req_peek=1 read the head without freeing or advancing it.
module ll_rd_ctrl
  import ll_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = ll_pkg::DATA_DEPTH,
  parameter int unsigned PTR_WD     = $clog2(DATA_DEPTH),
  parameter int unsigned DATA_WD    = ll_pkg::DATA_WD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rd_req_vld,
  input  logic               rd_req_peek,
  output logic               rd_req_rdy,
  output logic               rd_resp_vld,
  input  logic               rd_resp_rdy,
  output logic [DATA_WD-1:0] rd_resp_data,
  output logic               rd_resp_err,
  input  logic               head_ld,
  input  logic [PTR_WD-1:0]  head_ld_ptr,
  input  logic               ll_empty,
  input  logic               make_ll_empty,
  output logic               mem_rd_en,
  output logic [PTR_WD-1:0]  mem_rd_addr,
  input  logic [DATA_WD-1:0] mem_rd_data,
  input  logic [PTR_WD-1:0]  mem_rd_nxt_ptr,
  output logic               return_nxt_ptr,
  output logic [PTR_WD-1:0]  pos_2_return_nxt_ptr
);

  rd_state_e         state, state_nxt;
  logic [PTR_WD-1:0] head_ptr;
  logic              head_vld;
  logic [PTR_WD-1:0] nxt_q;
  logic              peek_q;
  rd_resp_t          resp_q;
  logic              ret_pulse;
  logic [PTR_WD-1:0] ret_ptr;

  logic req_acc;
  logic resp_acc;
  logic pop_done;
  logic pop_empties;
  logic head_ld_ok;
  logic req_peek;

`ifdef LL_PEEK_EN
  assign req_peek = rd_req_peek;
`else
  logic unused_peek;
  assign req_peek    = 1'b0;
  assign unused_peek = rd_req_peek;
`endif

  assign req_acc     = (state == IDLE) && rd_req_vld;
  assign resp_acc    = (state == RESP) && rd_resp_rdy;
  assign pop_done    = resp_acc && !resp_q.err && !peek_q;
  // A node pointing at itself is the tail, so freeing it empties the list.
  assign pop_empties = pop_done && (nxt_q == head_ptr);
  // A load is only honoured into an empty list, including one emptied this very cycle.
  assign head_ld_ok  = head_ld && (!head_vld || pop_empties);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_req_rdy  = 1'b0;
    rd_resp_vld = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    unique case (state)
      IDLE: begin
        rd_req_rdy = 1'b1;
        if (rd_req_vld) begin
          state_nxt = head_vld ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = head_ptr;
        state_nxt   = WAIT;
      end
      WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        rd_resp_vld = 1'b1;
        if (rd_resp_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (make_ll_empty) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      head_ptr  <= '0;
      head_vld  <= 1'b0;
      nxt_q     <= '0;
      peek_q    <= 1'b0;
      resp_q    <= '0;
      ret_pulse <= 1'b0;
      ret_ptr   <= '0;
    end else begin
      ret_pulse <= 1'b0;
      ret_ptr   <= '0;
      if (make_ll_empty) begin
        // Allocator resets itself on flush, so in-flight nodes are not returned.
        head_vld <= 1'b0;
      end else begin
        if (req_acc) begin
          peek_q <= req_peek;
          if (!head_vld) begin
            resp_q <= '{data: '0, err: 1'b1};
          end
        end
        if (state == WAIT) begin
          resp_q <= '{data: mem_rd_data, err: 1'b0};
          nxt_q  <= mem_rd_nxt_ptr;
        end
        if (pop_done) begin
          ret_pulse <= 1'b1;
          ret_ptr   <= head_ptr;
          if (pop_empties) begin
            head_vld <= 1'b0;
          end else begin
            head_ptr <= nxt_q;
          end
        end
        // Allocator reporting empty while we hold a head: trust the allocator.
        if (ll_empty && head_vld) begin
          head_vld <= 1'b0;
        end
        if (head_ld_ok) begin
          head_ptr <= head_ld_ptr;
          head_vld <= 1'b1;
        end
      end
    end
  end

  assign rd_resp_data         = resp_q.data;
  assign rd_resp_err          = resp_q.err;
  assign return_nxt_ptr       = ret_pulse;
  assign pos_2_return_nxt_ptr = ret_ptr;

endmodule
